// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register round-robin arbiter.
// State encoding and constant-function helpers for width derivation.
package shared_reg_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from
// i_ptr upward with wrap-around. Produces the winner index and one-hot form.
module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_winner,
    output logic [NUM_REQ-1:0] o_onehot
);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest position back to ptr so the nearest set bit wins last.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        o_onehot = '0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
        end
        if (o_any) begin
            o_onehot = NUM_REQ'(1) << o_winner;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one hold/load data register among NUM_REQ
// requesters. A grant lasts at most MAX_HOLD loads and is always followed
// by one idle cycle. Optional build macro SHARED_REG_ARB_LOCK_EN adds a
// lock input that lets the current owner keep the register past MAX_HOLD.
//
// Request/grant protocol: req[i] is a level; a requester owns the register
// while gnt[i] is high and every edge on which it still holds req[i] loads
// data[i] into q (q_upd pulses the cycle after). Dropping req releases.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef SHARED_REG_ARB_LOCK_EN
    input  logic                      lock,
`endif
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [IDX_W-1:0]          owner,
    output logic [DATA_W-1:0]         q,
    output logic                      q_upd,
    output logic                      o_dbg_state
);

    localparam int                CNT_W   = clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_HOLD);

    logic                r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]    r_owner, w_owner_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [DATA_W-1:0]   r_q, w_q_nxt;
    logic                r_q_upd, w_q_upd_nxt;

    logic                w_any;
    logic [IDX_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_onehot;
    logic                w_req_own;
    logic [DATA_W-1:0]   w_owner_data;
    logic                w_cap;
    logic                w_load;
    logic                w_release;
    logic [IDX_W-1:0]    w_ptr_after;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_winner),
        .o_onehot (w_onehot)
    );

    assign w_req_own    = req[r_owner];
    assign w_owner_data = data[int'(r_owner) * DATA_W +: DATA_W];
    assign w_ptr_after  = IDX_W'((int'(r_owner) + 1) % NUM_REQ);

`ifdef SHARED_REG_ARB_LOCK_EN
    // While locked the hold cap is ignored; once unlocked, a full count releases.
    assign w_cap = lock ? 1'b0 : ((r_cnt == CNT_MAX) || (r_cnt + 1'b1 == CNT_MAX));
`else
    assign w_cap = (r_cnt + 1'b1 == CNT_MAX);
`endif

    assign w_load    = (r_state == ST_OWN) && w_req_own;
    assign w_release = (r_state == ST_OWN) && (!w_req_own || w_cap);

    assign gnt         = r_gnt;
    assign owner       = r_owner;
    assign q           = r_q;
    assign q_upd       = r_q_upd;
    assign o_dbg_state = r_state;

    // State register plus the registered datapath; reset aborts any grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_q     <= '0;
            r_q_upd <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_q     <= w_q_nxt;
            r_q_upd <= w_q_upd_nxt;
        end
    end

    // Next state: grant on any request in IDLE, return to IDLE on release.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)     w_state_nxt = ST_OWN;
            ST_OWN:  if (w_release) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Next outputs and datapath: grant capture, loads, counting and release.
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_q_nxt     = r_q;
        w_q_upd_nxt = 1'b0;
        if ((r_state == ST_IDLE) && w_any) begin
            w_owner_nxt = w_winner;
            w_gnt_nxt   = w_onehot;
            w_cnt_nxt   = '0;
        end
        if (w_load) begin
            w_q_nxt     = w_owner_data;
            w_q_upd_nxt = 1'b1;
            w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
        if (w_release) begin
            w_gnt_nxt = '0;
            w_ptr_nxt = w_ptr_after;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
// Inputs change on the falling edge; outputs are compared 1 ns after the
// rising edge against expectations taken from a FIFO of expected words.
module tb_shared_reg_arbiter;

    localparam int EXP_W = 4 + 2 + 8 + 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic [7:0]  q;
        logic        q_upd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        lock;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        q_upd;
    logic        dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int checks;
    int errors;

    vec_t tbl[8];

    shared_reg_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SHARED_REG_ARB_LOCK_EN
        .lock        (lock),
`endif
        .req         (req),
        .data        (data),
        .gnt         (gnt),
        .owner       (owner),
        .q           (q),
        .q_upd       (q_upd),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: pop one expected word and compare against the live outputs.
    task automatic check(input string tag);
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty", tag);
            return;
        end
        e = exp_q.pop_front();
        a = {gnt, owner, q, q_upd};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got gnt=%b owner=%0d q=%h q_upd=%b, want gnt=%b owner=%0d q=%h q_upd=%b",
                     tag, a[14:11], a[10:9], a[8:1], a[0], e[14:11], e[10:9], e[8:1], e[0]);
        end
    endtask

    // Driver: apply inputs on the falling edge, queue the post-edge expectation.
    task automatic step(input logic [3:0] r, input logic [31:0] d,
                        input logic [3:0] eg, input logic [1:0] eo,
                        input logic [7:0] eq, input logic eu, input string tag);
        @(negedge clk);
        req  = r;
        data = d;
        exp_q.push_back({eg, eo, eq, eu});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        logic [7:0] prev_q;
        logic [7:0] word;
        logic [3:0] oh;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        data   = 32'h0;
        lock   = 1'b0;

        // Single requester 1 holding 8'h3C: grant, four loads, bubble, re-grant.
        tbl[0] = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h00, 1'b0};
        tbl[1] = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h3C, 1'b1};
        tbl[2] = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h3C, 1'b1};
        tbl[3] = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h3C, 1'b1};
        tbl[4] = '{4'b0010, 32'h0000_3C00, 4'b0000, 2'd1, 8'h3C, 1'b1};
        tbl[5] = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h3C, 1'b0};
        tbl[6] = '{4'b0010, 32'h0000_3C00, 4'b0010, 2'd1, 8'h3C, 1'b1};
        tbl[7] = '{4'b0010, 32'h0000_3D00, 4'b0010, 2'd1, 8'h3D, 1'b1};

        do_reset();
        #1;
        exp_q.push_back({4'b0000, 2'd0, 8'h00, 1'b0});
        check("reset_state");

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].req, tbl[i].data, tbl[i].gnt, tbl[i].owner,
                 tbl[i].q, tbl[i].q_upd, $sformatf("single_%0d", i));
        end

        // Round robin with all four requesting: owners 0,1,2,3,0.
        do_reset();
        prev_q = 8'h00;
        for (int g = 0; g < 5; g++) begin
            int o;
            o    = g % 4;
            oh   = 4'b0001 << o;
            word = 8'(16 * (o + 1));
            step(4'hF, 32'h4030_2010, oh, 2'(o), prev_q, 1'b0, $sformatf("rr_grant_%0d", g));
            for (int k = 1; k <= 4; k++) begin
                step(4'hF, 32'h4030_2010, (k < 4) ? oh : 4'b0000, 2'(o), word, 1'b1,
                     $sformatf("rr_load_%0d_%0d", g, k));
            end
            prev_q = word;
        end

        // Asynchronous reset in the middle of a grant held by requester 2.
        do_reset();
        step(4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'h00, 1'b0, "mid_grant");
        step(4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5, 1'b1, "mid_load");
        #2;
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        exp_q.push_back({4'b0000, 2'd0, 8'h00, 1'b0});
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Early drop by owner 2, hand-over to 3, then wrap to 0, then idle hold.
        do_reset();
        step(4'b0100, 32'h0071_0000, 4'b0100, 2'd2, 8'h00, 1'b0, "drop_grant2");
        step(4'b0100, 32'h0071_0000, 4'b0100, 2'd2, 8'h71, 1'b1, "drop_load1");
        step(4'b0100, 32'h0072_0000, 4'b0100, 2'd2, 8'h72, 1'b1, "drop_load2");
        step(4'b1000, 32'h55EE_0000, 4'b0000, 2'd2, 8'h72, 1'b0, "drop_release");
        step(4'b1000, 32'h55EE_0000, 4'b1000, 2'd3, 8'h72, 1'b0, "drop_grant3");
        step(4'b1000, 32'h55EE_0000, 4'b1000, 2'd3, 8'h55, 1'b1, "drop_load3");
        step(4'b0001, 32'h0000_0066, 4'b0000, 2'd3, 8'h55, 1'b0, "wrap_release");
        step(4'b0001, 32'h0000_0066, 4'b0001, 2'd0, 8'h55, 1'b0, "wrap_grant0");
        step(4'b0000, 32'h0000_0066, 4'b0000, 2'd0, 8'h55, 1'b0, "idle_release");
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, $urandom_range(32'hFFFF_FFFF, 0), 4'b0000, 2'd0, 8'h55, 1'b0,
                 $sformatf("hold_%0d", i));
        end

`ifdef SHARED_REG_ARB_LOCK_EN
        // Locked owner 0 loads past the cap; unlocking releases, owner 2 follows.
        do_reset();
        lock = 1'b1;
        step(4'b0101, 32'h0022_0011, 4'b0001, 2'd0, 8'h00, 1'b0, "lock_grant");
        for (int k = 1; k <= 7; k++) begin
            step(4'b0101, 32'h0022_0011, 4'b0001, 2'd0, 8'h11, 1'b1, $sformatf("lock_load_%0d", k));
        end
        lock = 1'b0;
        step(4'b0101, 32'h0022_0011, 4'b0000, 2'd0, 8'h11, 1'b1, "lock_release");
        step(4'b0101, 32'h0022_0011, 4'b0100, 2'd2, 8'h11, 1'b0, "lock_next");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
